tester_status_monitor: RTL and testbench

- Sits directly downstream of the top-level tester inside the simulation harness; consumes the tester's completion, error and progress signals.
- Counts post-reset cycles, runs a global timeout and a hang (no-progress) watchdog, and latches a single final verdict with an exit code.
- Holds the verdict through a short drain window before asserting finished, so waveform dumps capture trailing activity.
- Fully synthesizable; also usable on FPGA emulation.

---
 rtl/tester_status_monitor.sv | 157 +++++++++++++++
 tb/tb_tester_status_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tester_status_monitor.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tester_status_monitor
//  Function : Cycle counter, global timeout and hang watchdog that latch one
//             final verdict/exit code, then assert finished after a drain.
//  Revision : 1.0
// ============================================================================
module tester_status_monitor #(
    parameter int CYCLE_W      = 64,
    parameter int CODE_W       = 8,
    parameter int MAX_CYCLES   = 1000000,
    parameter int HANG_CYCLES  = 10000,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tester_done,
    input  logic               tester_error,
    input  logic [CODE_W-1:0]  tester_error_code,
    input  logic               progress,
    output logic [CYCLE_W-1:0] cycle,
    output logic               verdict_valid,
    output logic               passed,
    output logic               failed,
    output logic               timeout,
    output logic               hang,
    output logic [CODE_W-1:0]  exit_code,
    output logic               finished
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [CYCLE_W-1:0] c_cycle_last  = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] c_hang_last   =
        CYCLE_W'((HANG_CYCLES > 0) ? HANG_CYCLES - 1 : 0);
    localparam logic [DRAIN_W-1:0] c_drain_load  =
        DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam bit                 c_hang_en     = (HANG_CYCLES != 0);
    localparam bit                 c_no_drain    = (DRAIN_CYCLES == 0);
    localparam logic [CODE_W-1:0]  c_code_tmo    = '1;
    localparam logic [CODE_W-1:0]  c_code_hang   = {{(CODE_W-1){1'b1}}, 1'b0};
    localparam logic [CODE_W-1:0]  c_code_one    = CODE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CYCLE_W-1:0]  r_cycle;
    logic [CYCLE_W-1:0]  r_hang_cnt;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic                r_verdict_valid;
    logic                r_passed;
    logic                r_failed;
    logic                r_timeout;
    logic                r_hang;
    logic [CODE_W-1:0]   r_exit_code;
    logic                r_finished;

    logic [CYCLE_W-1:0]  w_cycle_inc;
    logic [CYCLE_W-1:0]  w_hang_inc;
    logic                w_hang_hit;
    logic                w_timeout_hit;
    logic                w_event;
    logic [CODE_W-1:0]   w_err_code;

    always_comb begin
        w_cycle_inc   = (r_cycle == '1)    ? r_cycle    : r_cycle + CYCLE_W'(1);
        w_hang_inc    = (r_hang_cnt == '1) ? r_hang_cnt : r_hang_cnt + CYCLE_W'(1);
        // A progress pulse on the would-be hang edge rescues the run.
        w_hang_hit    = c_hang_en && (r_hang_cnt == c_hang_last) && !progress;
        w_timeout_hit = (r_cycle == c_cycle_last);
        w_event       = tester_error | tester_done | w_hang_hit | w_timeout_hit;
        w_err_code    = (tester_error_code == '0) ? c_code_one : tester_error_code;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_cycle         <= '0;
            r_hang_cnt      <= '0;
            r_drain_cnt     <= '0;
            r_verdict_valid <= 1'b0;
            r_passed        <= 1'b0;
            r_failed        <= 1'b0;
            r_timeout       <= 1'b0;
            r_hang          <= 1'b0;
            r_exit_code     <= '0;
            r_finished      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_cycle    <= w_cycle_inc;
                    r_hang_cnt <= progress ? '0 : w_hang_inc;
                    if (w_event) begin
                        r_verdict_valid <= 1'b1;
                        if (tester_error) begin
                            r_failed    <= 1'b1;
                            r_exit_code <= w_err_code;
                        end else if (tester_done) begin
                            r_passed    <= 1'b1;
                            r_exit_code <= '0;
                        end else if (w_hang_hit) begin
                            r_failed    <= 1'b1;
                            r_hang      <= 1'b1;
                            r_exit_code <= c_code_hang;
                        end else begin
                            r_failed    <= 1'b1;
                            r_timeout   <= 1'b1;
                            r_exit_code <= c_code_tmo;
                        end
                        if (c_no_drain) begin
                            r_state    <= S_DONE;
                            r_finished <= 1'b1;
                        end else begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= c_drain_load;
                        end
                    end
                end
                S_DRAIN: begin
                    r_cycle <= w_cycle_inc;
                    if (r_drain_cnt == '0) begin
                        r_state    <= S_DONE;
                        r_finished <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cycle         = r_cycle;
    assign verdict_valid = r_verdict_valid;
    assign passed        = r_passed;
    assign failed        = r_failed;
    assign timeout       = r_timeout;
    assign hang          = r_hang;
    assign exit_code     = r_exit_code;
    assign finished      = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_tester_status_monitor.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_tester_status_monitor
//  Function : Scoreboard bench; four monitor instances with different limits.
//  Revision : 1.0
// ============================================================================
module tb_tester_status_monitor;

    typedef struct packed {
        logic        fin;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic        hng;
        logic [7:0]  code;
        logic [63:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn   [4];
    logic        done_i [4];
    logic        err_i  [4];
    logic        prog_i [4];
    logic [7:0]  code_i [4];
    logic [63:0] cyc    [4];
    logic        vv     [4];
    logic        pas    [4];
    logic        fal    [4];
    logic        tmo    [4];
    logic        hng    [4];
    logic        fin    [4];
    logic [7:0]  xc     [4];

    exp_t sbq [4][$];
    int   total = 0;
    int   bad   = 0;

    // 0: pass/error paths, 1: timeout with no drain, 2: hang watchdog, 3: hang/timeout tie
    tester_status_monitor #(.CYCLE_W(64), .CODE_W(8), .MAX_CYCLES(1000), .HANG_CYCLES(0), .DRAIN_CYCLES(4)) u_a (
        .clock(clk), .reset(rstn[0]), .tester_done(done_i[0]), .tester_error(err_i[0]),
        .tester_error_code(code_i[0]), .progress(prog_i[0]), .cycle(cyc[0]), .verdict_valid(vv[0]),
        .passed(pas[0]), .failed(fal[0]), .timeout(tmo[0]), .hang(hng[0]), .exit_code(xc[0]), .finished(fin[0]));
    tester_status_monitor #(.CYCLE_W(64), .CODE_W(8), .MAX_CYCLES(50), .HANG_CYCLES(0), .DRAIN_CYCLES(0)) u_b (
        .clock(clk), .reset(rstn[1]), .tester_done(done_i[1]), .tester_error(err_i[1]),
        .tester_error_code(code_i[1]), .progress(prog_i[1]), .cycle(cyc[1]), .verdict_valid(vv[1]),
        .passed(pas[1]), .failed(fal[1]), .timeout(tmo[1]), .hang(hng[1]), .exit_code(xc[1]), .finished(fin[1]));
    tester_status_monitor #(.CYCLE_W(64), .CODE_W(8), .MAX_CYCLES(1000), .HANG_CYCLES(8), .DRAIN_CYCLES(2)) u_c (
        .clock(clk), .reset(rstn[2]), .tester_done(done_i[2]), .tester_error(err_i[2]),
        .tester_error_code(code_i[2]), .progress(prog_i[2]), .cycle(cyc[2]), .verdict_valid(vv[2]),
        .passed(pas[2]), .failed(fal[2]), .timeout(tmo[2]), .hang(hng[2]), .exit_code(xc[2]), .finished(fin[2]));
    tester_status_monitor #(.CYCLE_W(64), .CODE_W(8), .MAX_CYCLES(8), .HANG_CYCLES(8), .DRAIN_CYCLES(1)) u_d (
        .clock(clk), .reset(rstn[3]), .tester_done(done_i[3]), .tester_error(err_i[3]),
        .tester_error_code(code_i[3]), .progress(prog_i[3]), .cycle(cyc[3]), .verdict_valid(vv[3]),
        .passed(pas[3]), .failed(fal[3]), .timeout(tmo[3]), .hang(hng[3]), .exit_code(xc[3]), .finished(fin[3]));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int i, input logic f_fin, input logic p, input logic f,
                        input logic t, input logic h, input logic [7:0] code, input logic [63:0] c);
        exp_t e;
        e.fin  = f_fin;
        e.pass = p;
        e.fail = f;
        e.tmo  = t;
        e.hng  = h;
        e.code = code;
        e.cyc  = c;
        sbq[i].push_back(e);
    endtask

    // Positioned just after a negedge; advance n RUN edges.
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Release reset and step through the IDLE->RUN edge (RUN edge count 0).
    task automatic start(input int i);
        @(negedge clk);
        rstn[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic proc_a();
        start(0);
        push(0, 0, 1, 0, 0, 0, 8'h00, 64'd100);
        push(0, 1, 1, 0, 0, 0, 8'h00, 64'd104);
        edges(99); done_i[0] = 1'b1; edges(1); done_i[0] = 1'b0;
        edges(10);

        rstn[0] = 1'b0; edges(1); start(0);
        push(0, 0, 0, 1, 0, 0, 8'h01, 64'd30);
        push(0, 1, 0, 1, 0, 0, 8'h01, 64'd34);
        edges(29);
        err_i[0] = 1'b1; code_i[0] = 8'h00; done_i[0] = 1'b1;
        edges(1);
        err_i[0] = 1'b0; done_i[0] = 1'b1;
        edges(1);
        done_i[0] = 1'b0; err_i[0] = 1'b1; code_i[0] = 8'h33;
        edges(1);
        err_i[0] = 1'b0; code_i[0] = 8'h00;
        edges(6);

        rstn[0] = 1'b0; edges(1); start(0);
        push(0, 0, 0, 1, 0, 0, 8'h5A, 64'd7);
        push(0, 1, 0, 1, 0, 0, 8'h5A, 64'd11);
        edges(6); err_i[0] = 1'b1; code_i[0] = 8'h5A; edges(1); err_i[0] = 1'b0; code_i[0] = 8'h00;
        edges(8);

        rstn[0] = 1'b0; edges(1); start(0);
        push(0, 0, 1, 0, 0, 0, 8'h00, 64'd10);
        edges(9); done_i[0] = 1'b1; edges(1); done_i[0] = 1'b0;
        edges(2);
        #2;
        rstn[0] = 1'b0;
        #0.5;
        chk("dut0 reset mid-drain", {cyc[0], vv[0], pas[0], fal[0], tmo[0], hng[0], xc[0], fin[0]}, '0);
        #0.5;
        rstn[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        push(0, 0, 1, 0, 0, 0, 8'h00, 64'd20);
        push(0, 1, 1, 0, 0, 0, 8'h00, 64'd24);
        edges(19); done_i[0] = 1'b1; edges(1); done_i[0] = 1'b0;
        edges(8);
    endtask

    // cycle==MAX_CYCLES-1 is the pre-edge value on the 50th RUN edge.
    task automatic proc_b();
        start(1);
        push(1, 0, 0, 1, 1, 0, 8'hFF, 64'd50);
        push(1, 1, 0, 1, 1, 0, 8'hFF, 64'd50);
        edges(60);
    endtask

    task automatic proc_c();
        start(2);
        push(2, 0, 0, 1, 0, 1, 8'hFE, 64'd29);
        push(2, 1, 0, 1, 0, 1, 8'hFE, 64'd31);
        for (int j = 0; j < 5; j++) begin
            prog_i[2] = 1'b1; edges(1); prog_i[2] = 1'b0;
            if (j < 4) edges(4);
        end
        edges(12);

        rstn[2] = 1'b0; edges(1); start(2);
        push(2, 0, 0, 1, 0, 1, 8'hFE, 64'd37);
        push(2, 1, 0, 1, 0, 1, 8'hFE, 64'd39);
        for (int j = 0; j < 5; j++) begin
            prog_i[2] = 1'b1; edges(1); prog_i[2] = 1'b0;
            if (j < 4) edges(4);
        end
        edges(7);
        prog_i[2] = 1'b1; edges(1); prog_i[2] = 1'b0;
        edges(12);
    endtask

    task automatic proc_d();
        start(3);
        push(3, 0, 0, 1, 0, 1, 8'hFE, 64'd8);
        push(3, 1, 0, 1, 0, 1, 8'hFE, 64'd9);
        edges(15);
    endtask

    logic        pv  [4];
    logic        pf  [4];
    logic [11:0] held_f [4];
    logic [63:0] held_c [4];

    initial begin
        exp_t        e;
        logic [11:0] fld;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0; pf[i] = 1'b0; held_f[i] = '0; held_c[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                fld = {pas[i], fal[i], tmo[i], hng[i], xc[i]};
                if (vv[i] && !pv[i]) begin
                    if (sbq[i].size() == 0) begin
                        chk($sformatf("dut%0d unexpected verdict", i), {fld, cyc[i]}, '0);
                    end else begin
                        e = sbq[i].pop_front();
                        chk($sformatf("dut%0d event kind", i), 128'(1'b0), 128'(e.fin));
                        chk($sformatf("dut%0d verdict", i), {fld, cyc[i]},
                            {e.pass, e.fail, e.tmo, e.hng, e.code, e.cyc});
                    end
                    held_f[i] = fld;
                end else if (vv[i] && pv[i]) begin
                    chk($sformatf("dut%0d verdict held", i), fld, held_f[i]);
                end
                if (vv[i])
                    chk($sformatf("dut%0d invariants", i),
                        {pas[i] & fal[i], tmo[i] & hng[i], (xc[i] == 8'h00) != pas[i]}, '0);
                if (fin[i] && !pf[i]) begin
                    if (sbq[i].size() == 0) begin
                        chk($sformatf("dut%0d unexpected finished", i), {fld, cyc[i]}, '0);
                    end else begin
                        e = sbq[i].pop_front();
                        chk($sformatf("dut%0d event kind", i), 128'(1'b1), 128'(e.fin));
                        chk($sformatf("dut%0d finished", i), {fld, cyc[i]},
                            {e.pass, e.fail, e.tmo, e.hng, e.code, e.cyc});
                    end
                    held_c[i] = cyc[i];
                end else if (fin[i] && pf[i]) begin
                    chk($sformatf("dut%0d cycle frozen", i), cyc[i], held_c[i]);
                end
                pv[i] = vv[i];
                pf[i] = fin[i];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rstn[i] = 1'b0; done_i[i] = 1'b0; err_i[i] = 1'b0;
            prog_i[i] = 1'b0; code_i[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("dut%0d reset state", i),
                {cyc[i], vv[i], pas[i], fal[i], tmo[i], hng[i], xc[i], fin[i]}, '0);
        fork
            proc_a();
            proc_b();
            proc_c();
            proc_d();
        join
        edges(4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("dut%0d events outstanding", i), sbq[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
